fetch_unit_legv8: RTL and testbench
===================================

// Module: fetch_unit_legv8
// PURPOSE
//   Instruction-fetch stage feeding ControlUnit_LEGv8. Holds the program counter (PC) and the
//   instruction register (IR). Fetches one 32-bit instruction per IL request over a req/ack
//   instruction-memory handshake, and applies the control unit's PS field to update the PC.
//   Drives `instruction` into the control unit and `pc_plus4` to the datapath for BL links.
//   Asserts `stall` while a fetch is in flight; the control unit holds its state while `stall` is high.
// PARAMETERS
//   RESET_PC  64'h0  PC value loaded on reset
//   TIMEOUT   255    maximum cycles in WAIT without imem_ack before a fault is raised (1..255)
// PORTS
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous reset, active-high
//   il           in   1   instruction load: start a fetch at the current pc
//   ps           in   2   PC select: 00 hold, 01 pc+4, 10 reg_target, 11 ir_pc+(constant<<2)
//   constant     in   64  sign-extended offset from the constant generator, in words
//   reg_target   in   64  register-file A bus, used for BR/BLR/RET
//   imem_req     out  1   fetch request, held until ack
//   imem_addr    out  64  fetch address (equals pc while imem_req is high)
//   imem_ack     in   1   read data valid this cycle
//   imem_rdata   in   32  instruction word
//   instruction  out  32  IR contents
//   pc           out  64  address of the next fetch
//   pc_plus4     out  64  ir_pc + 4 (link value), combinational
//   stall        out  1   fetch pending; control unit must hold its state
//   fetch_fault  out  1   sticky fault: misaligned fetch or timeout
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, ir_pc=RESET_PC, instruction=32'h0, imem_req=0, fetch_fault=0,
//     state=IDLE, timeout count=0. Reset mid-fetch abandons the fetch; a late ack is ignored.
//   FSM states: IDLE, WAIT.
//   IDLE:
//     - il=1, fetch_fault=0, pc[1:0]==0: assert imem_req (combinationally, same cycle); go to WAIT.
//     - il=1, pc[1:0]!=0: set fetch_fault; no request; stay in IDLE.
//     - il=1, fetch_fault=1: no request; stay in IDLE; stall=0.
//     - il=0: pc updated per ps on the clock edge. The ps field is ignored whenever il=1 (il wins).
//     - imem_ack in IDLE is ignored.
//   WAIT:
//     - imem_req=1; imem_addr stable at pc.
//     - On imem_ack: instruction<=imem_rdata, ir_pc<=pc, pc<=pc+4, count<=0; go to IDLE.
//     - With no ack: count increments. When count reaches TIMEOUT-1 without an ack, set fetch_fault,
//       drop imem_req next cycle, go to IDLE; IR and PC are unchanged.
//   stall = (state==WAIT) | (state==IDLE & il & ~fetch_fault & pc[1:0]==0).
//     - Minimum fetch latency: request cycle plus ack cycle. With ack in the first WAIT cycle, stall is
//       high for 2 cycles and the new IR is visible in the cycle after ack.
//   PS arithmetic:
//     - All sums are modulo 2^64 (wrap-around, no flag).
//     - ps=11 target = ir_pc + {constant[61:0],2'b00}, relative to the address of the executing
//       instruction, not pc.
//     - ps=10 loads reg_target unchanged. A misaligned target is accepted and faults on the next fetch.
//   fetch_fault is cleared only by reset.
// TESTING
//   T1 reset, then il pulse with 1-cycle ack, rdata=32'h91000421 -> instruction=32'h91000421,
//      pc=RESET_PC+4, pc_plus4=RESET_PC+4, stall high exactly 2 cycles.
//   T2 ir_pc=64'h100, ps=11, constant=-2 -> pc=64'hF8; ps=11, constant=3 -> pc=64'h10C.
//   T3 ps=10, reg_target=64'h2002, then il -> fetch_fault=1, imem_req never asserted, pc stays 64'h2002.
//   T4 ack delayed 5 cycles with TIMEOUT=255 -> imem_addr stable across all WAIT cycles, IR loads on ack.
//      No ack for TIMEOUT cycles -> fetch_fault=1, imem_req drops, IR unchanged.
//   T5 il=1 and ps=01 in the same cycle -> only the fetch advances pc (+4 total, not +8).
//      ack while IDLE -> no IR change.
//   T6 pc=64'hFFFF_FFFF_FFFF_FFFC fetch -> pc wraps to 64'h0.
//      reset asserted in WAIT -> imem_req=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/fetch_unit_legv8.sv
// Fetch stage: PC/IR, req/ack fetch (>=2 cycles: request + ack); stall held while a fetch is in flight.
// Waits on imem_ack with a bounded timeout; misaligned fetches and timeouts raise a sticky fault.
module fetch_unit_legv8 #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        il,
  input  logic [1:0]  ps,
  input  logic [63:0] constant,
  input  logic [63:0] reg_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        stall,
  output logic        fetch_fault
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ir_pc_q, ir_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        fetch_go;
  logic [63:0] branch_target;

  // Reset also gates the request so an abandoned fetch is withdrawn immediately.
  assign fetch_go      = (state_q == S_IDLE) & il & ~fault_q & (pc_q[1:0] == 2'b00) & ~reset;
  assign branch_target = ir_pc_q + (constant << 2);

  assign imem_req    = (state_q == S_WAIT) | fetch_go;
  assign imem_addr   = pc_q;
  assign stall       = imem_req;
  assign instruction = ir_q;
  assign pc          = pc_q;
  assign pc_plus4    = ir_pc_q + 64'd4;
  assign fetch_fault = fault_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_pc_d = ir_pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (il) begin
          // A pending load takes priority over any PC select in the same cycle.
          if (!fault_q) begin
            if (pc_q[1:0] != 2'b00) begin
              fault_d = 1'b1;
            end else begin
              state_d = S_WAIT;
              cnt_d   = 8'd0;
            end
          end
        end else begin
          case (ps)
            2'b01:   pc_d = pc_q + 64'd4;
            2'b10:   pc_d = reg_target;
            2'b11:   pc_d = branch_target;
            default: pc_d = pc_q;
          endcase
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          ir_pc_d = pc_q;
          pc_d    = pc_q + 64'd4;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_pc_q <= RESET_PC;
      ir_q    <= 32'h0;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_pc_q <= ir_pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit_legv8.sv
// Bench for fetch_unit_legv8: directed fetch/PC-select vectors, completed fetches checked by a scoreboard monitor.
module tb_fetch_unit_legv8;

  localparam int TIMEOUT = 255;

  logic        clock;
  logic        reset;
  logic        il;
  logic [1:0]  ps;
  logic [63:0] constant;
  logic [63:0] reg_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        stall;
  logic        fetch_fault;

  fetch_unit_legv8 #(.RESET_PC(64'h0), .TIMEOUT(TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .il          (il),
    .ps          (ps),
    .constant    (constant),
    .reg_target  (reg_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .stall       (stall),
    .fetch_fault (fetch_fault)
  );

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
    logic [63:0] pcp4;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Completion monitor: a WAIT cycle is a cycle with req high that was also high the cycle before
  // without finishing; the IR/PC result is compared one cycle after the ack.
  logic prev_req, prev_done, pend;
  always @(negedge clock) begin : monitor
    logic m_wait, m_done;
    exp_t e;
    if (reset) begin
      prev_req  <= 1'b0;
      prev_done <= 1'b0;
      pend      <= 1'b0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          chk("unexpected fetch completion", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb instruction", {32'h0, instruction}, {32'h0, e.ins});
          chk("sb pc", pc, e.pc);
          chk("sb pc_plus4", pc_plus4, e.pcp4);
        end
      end
      m_wait = prev_req && !prev_done && imem_req;
      m_done = m_wait && imem_ack;
      prev_req  <= imem_req;
      prev_done <= m_done;
      pend      <= m_done;
    end
  end

  task automatic apply_ps(input logic [1:0] p);
    ps = p;
    cyc();
    ps = 2'b00;
  endtask

  task automatic fetch(input string tag, input logic [63:0] ea, input logic [31:0] rd,
                       input int delay, input logic [1:0] psv);
    int st;
    exp_q.push_back('{rd, ea + 64'd4, ea + 64'd4});
    st = 0;
    il = 1'b1;
    ps = psv;
    #1;
    chk({tag, " req"}, {63'd0, imem_req}, 64'd1);
    chk({tag, " addr"}, imem_addr, ea);
    if (stall) st++;
    cyc();
    il = 1'b0;
    ps = 2'b00;
    for (int i = 0; i < delay; i++) begin
      #1;
      if (stall) st++;
      chk({tag, " wait addr"}, imem_addr, ea);
      cyc();
    end
    imem_ack   = 1'b1;
    imem_rdata = rd;
    #1;
    if (stall) st++;
    cyc();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    if (stall) st++;
    chk({tag, " stall cycles"}, 64'(st), 64'(delay + 2));
    cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc"}, pc, 64'h0);
    chk({tag, " instruction"}, {32'h0, instruction}, 64'h0);
    chk({tag, " pc_plus4"}, pc_plus4, 64'h4);
    chk({tag, " req"}, {63'd0, imem_req}, 64'd0);
    chk({tag, " stall"}, {63'd0, stall}, 64'd0);
    chk({tag, " fault"}, {63'd0, fetch_fault}, 64'd0);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    il         = 1'b0;
    ps         = 2'b00;
    constant   = 64'h0;
    reg_target = 64'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    cyc();

    // T1: basic fetch, single-cycle ack
    fetch("t1", 64'h0, 32'h9100_0421, 0, 2'b00);

    // T2: move to 0x100, fetch there, then relative branches from ir_pc
    reg_target = 64'h100;
    apply_ps(2'b10);
    #1 chk("t2 ps10 load", pc, 64'h100);
    fetch("t2 fetch", 64'h100, 32'h8B02_0020, 0, 2'b00);
    constant = -64'sd2;
    apply_ps(2'b11);
    #1 chk("t2 ps11 neg", pc, 64'hF8);
    constant = 64'd3;
    apply_ps(2'b11);
    #1 chk("t2 ps11 pos", pc, 64'h10C);
    apply_ps(2'b00);
    #1 chk("t2 ps00 hold", pc, 64'h10C);

    // T5: il and ps=01 together advance pc once; ack while idle is ignored
    fetch("t5", 64'h10C, 32'hD65F_03C0, 0, 2'b01);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_2222;
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("t5 idle ack ir", {32'h0, instruction}, {32'h0, 32'hD65F_03C0});
    chk("t5 idle ack pc", pc, 64'h110);

    // T4a: delayed ack, address held steady
    fetch("t4 delay", 64'h110, 32'hF840_03E0, 5, 2'b00);
    apply_ps(2'b01);
    #1 chk("t4 ps01", pc, 64'h118);

    // T6a: fetch at the top of the address space wraps to zero
    reg_target = 64'hFFFF_FFFF_FFFF_FFFC;
    apply_ps(2'b10);
    fetch("t6 wrap", 64'hFFFF_FFFF_FFFF_FFFC, 32'h1400_0001, 0, 2'b00);

    // T3: misaligned target accepted, fetch then faults without a request
    reg_target = 64'h2002;
    apply_ps(2'b10);
    #1 chk("t3 pc load", pc, 64'h2002);
    il = 1'b1;
    #1;
    chk("t3 no req", {63'd0, imem_req}, 64'd0);
    chk("t3 no stall", {63'd0, stall}, 64'd0);
    cyc();
    #1;
    chk("t3 fault", {63'd0, fetch_fault}, 64'd1);
    chk("t3 faulted no req", {63'd0, imem_req}, 64'd0);
    chk("t3 pc", pc, 64'h2002);
    cyc();
    il = 1'b0;

    // Clear the sticky fault
    reset = 1'b1;
    #1 chk_reset_vals("reset2");
    cyc();
    reset = 1'b0;
    cyc();

    // T4b: timeout with no ack leaves IR and PC untouched
    fetch("t4 pre", 64'h0, 32'hAA55_0F0F, 1, 2'b00);
    il = 1'b1;
    #1 chk("t4 to req", {63'd0, imem_req}, 64'd1);
    cyc();
    il = 1'b0;
    n = 0;
    while (n < 400) begin
      #1;
      if (!imem_req) break;
      n++;
      cyc();
    end
    chk("t4 timeout wait cycles", 64'(n), 64'(TIMEOUT));
    chk("t4 timeout fault", {63'd0, fetch_fault}, 64'd1);
    chk("t4 timeout ir", {32'h0, instruction}, {32'h0, 32'hAA55_0F0F});
    chk("t4 timeout pc", pc, 64'h4);
    cyc();

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();

    // T6b: reset in WAIT abandons the fetch; a late ack is ignored
    il = 1'b1;
    cyc();
    il = 1'b0;
    #1 chk("t6 in wait req", {63'd0, imem_req}, 64'd1);
    reset = 1'b1;
    #1 chk_reset_vals("t6 reset in wait");
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    cyc();
    reset = 1'b0;
    cyc();
    imem_ack = 1'b0;
    #1;
    chk("t6 late ack ir", {32'h0, instruction}, 64'h0);
    chk("t6 late ack pc", pc, 64'h0);
    chk("t6 late ack req", {63'd0, imem_req}, 64'd0);

    repeat (3) cyc();
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
